// File: rtl/rll_pkg.sv
// Shared types and constants for the RLL restore path.
package rll_pkg;

  localparam int unsigned BASE_BITS   = 2;
  localparam int unsigned DEF_MAX_RUN = 3;

  typedef logic [BASE_BITS-1:0] base_t;

endpackage : rll_pkg

// File: rtl/rll_keep_mask.sv
// Marks which bases of an encoded strand word survive stuffed-base removal.
// keep[i] corresponds to symbol i, where symbol 0 is the most significant base.
module rll_keep_mask
  import rll_pkg::*;
#(
  parameter int unsigned N       = 20,
  parameter int unsigned MAX_RUN = DEF_MAX_RUN
) (
  input  logic [BASE_BITS*N-1:0] word_in,
  output logic [N-1:0]           keep
);

  localparam int unsigned RUN_W = $clog2(MAX_RUN + 1);

  logic [RUN_W-1:0] run;
  base_t            prev;
  base_t            sym;

  // Scan symbols in stream order; the base after a full run is always dropped.
  always_comb begin
    keep = '0;
    run  = '0;
    prev = '0;
    sym  = '0;
    for (int i = 0; i < int'(N); i++) begin
      sym = word_in[BASE_BITS*(N-1-i) +: BASE_BITS];
      if (i == 0) begin
        keep[i] = 1'b1;
        run     = RUN_W'(1);
        prev    = sym;
      end else if (run == RUN_W'(MAX_RUN)) begin
        keep[i] = 1'b0;
        run     = '0;
      end else if ((run != '0) && (sym == prev)) begin
        keep[i] = 1'b1;
        run     = run + RUN_W'(1);
      end else begin
        keep[i] = 1'b1;
        run     = RUN_W'(1);
        prev    = sym;
      end
    end
  end

endmodule : rll_keep_mask

// File: rtl/rll_restore.sv
// RLL decoder: strips stuffed bases, keeps the tail of the restored stream
// and its bit length, registered one clock after word_in is sampled.
module rll_restore
  import rll_pkg::*;
#(
  parameter int unsigned N       = 20,
  parameter int unsigned MAX_RUN = DEF_MAX_RUN,
  parameter int unsigned OUT_W   = 14,
  parameter int unsigned LEN_W   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BASE_BITS*N-1:0] word_in,
  output logic [OUT_W-1:0]       word_out,
  output logic [LEN_W-1:0]       output_len
);

  logic [N-1:0]     keep_c;
  logic [OUT_W-1:0] packed_c;
  logic [LEN_W-1:0] len_c;

  rll_keep_mask #(
    .N       (N),
    .MAX_RUN (MAX_RUN)
  ) u_keep_mask (
    .word_in (word_in),
    .keep    (keep_c)
  );

  // Shift kept symbols in at the LSB end; older symbols fall off the top.
  always_comb begin
    packed_c = '0;
    len_c    = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (keep_c[i]) begin
        packed_c = (packed_c << BASE_BITS)
                 | OUT_W'(word_in[BASE_BITS*(N-1-i) +: BASE_BITS]);
        len_c    = len_c + LEN_W'(BASE_BITS);
      end
    end
  end

  // Output registers, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_out   <= '0;
      output_len <= '0;
    end else begin
      word_out   <= packed_c;
      output_len <= len_c;
    end
  end

endmodule : rll_restore

// File: tb/tb_rll_restore.sv
// Self-checking bench for rll_restore: queue-based reference model, per-cycle
// compare, and literal expectations that pin the model.
module tb_rll_restore;
  import rll_pkg::*;

  localparam int unsigned N       = 20;
  localparam int unsigned MAX_RUN = 3;
  localparam int unsigned OUT_W   = 14;
  localparam int unsigned LEN_W   = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic [2*N-1:0]   word_in;
  logic [OUT_W-1:0] word_out;
  logic [LEN_W-1:0] output_len;

  int vectors     = 0;
  int miscompares = 0;

  logic [OUT_W-1:0] exp_word;
  logic [LEN_W-1:0] exp_len;

  rll_restore #(
    .N       (N),
    .MAX_RUN (MAX_RUN),
    .OUT_W   (OUT_W),
    .LEN_W   (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_out   (word_out),
    .output_len (output_len)
  );

  always #5 clk = ~clk;

  // Reference: collect surviving bases into a queue, then read off its tail.
  function automatic void model(input logic [2*N-1:0] w,
                                output logic [OUT_W-1:0] ow,
                                output logic [LEN_W-1:0] ol);
    base_t kept[$];
    base_t s;
    base_t prev;
    int    run;
    prev = '0;
    run  = 0;
    for (int i = 0; i < int'(N); i++) begin
      s = w[2*N-1-2*i -: 2];
      if (i == 0) begin
        kept.push_back(s); run = 1; prev = s;
      end else if (run == int'(MAX_RUN)) begin
        run = 0;
      end else if (run > 0 && s == prev) begin
        kept.push_back(s); run++;
      end else begin
        kept.push_back(s); run = 1; prev = s;
      end
    end
    ow = '0;
    for (int k = 0; k < int'(OUT_W/2) && k < kept.size(); k++)
      ow[2*k +: 2] = kept[kept.size()-1-k];
    ol = LEN_W'(2*kept.size());
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected outputs track the registers: cleared by reset, reloaded each edge.
  always @(posedge clk or negedge rst) begin
    logic [OUT_W-1:0] tw;
    logic [LEN_W-1:0] tl;
    if (!rst) begin
      exp_word = '0;
      exp_len  = '0;
    end else begin
      model(word_in, tw, tl);
      exp_word = tw;
      exp_len  = tl;
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    check("cyc_word", 64'(word_out), 64'(exp_word));
    check("cyc_len", 64'(output_len), 64'(exp_len));
  end

  // Apply one word, pin the model to literals, then check the DUT after the edge.
  task automatic apply_pin(input logic [2*N-1:0] w, input logic [OUT_W-1:0] ew,
                           input logic [LEN_W-1:0] el);
    logic [OUT_W-1:0] tw;
    logic [LEN_W-1:0] tl;
    @(negedge clk);
    word_in = w;
    model(w, tw, tl);
    check("model_word", 64'(tw), 64'(ew));
    check("model_len", 64'(tl), 64'(el));
    @(posedge clk);
    #1;
    check("pin_word", 64'(word_out), 64'(ew));
    check("pin_len", 64'(output_len), 64'(el));
  endtask

  initial begin
    rst     = 1'b0;
    word_in = '0;
    #1;
    check("rst_word", 64'(word_out), 64'd0);
    check("rst_len", 64'(output_len), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    apply_pin(40'b0110110110110110110000000011010000011001, 14'b11010000011001, 7'd38);
    apply_pin(40'h0000000000, 14'h0000, 7'd30);
    apply_pin(40'h6666666666, 14'h2666, 7'd40);
    apply_pin(40'h66666666BF, 14'h26BF, 7'd40);
    apply_pin(40'h666666666F, 14'h266F, 7'd40);
    apply_pin(40'h66666666FF, 14'h19BF, 7'd38);
    apply_pin(40'hFFFFFFFFFF, 14'h3FFF, 7'd30);

    // Mid-cycle input change must not reach the outputs before the next edge.
    #2 word_in = 40'h6666666666;
    #1;
    check("mid_word", 64'(word_out), 64'h3FFF);
    check("mid_len", 64'(output_len), 64'd30);
    @(posedge clk);
    #1;
    check("mid_next_word", 64'(word_out), 64'h2666);
    check("mid_next_len", 64'(output_len), 64'd40);

    // Reset pulse between edges: clears at once, holds, reloads after release.
    word_in = 40'h0000000000;
    #2 rst = 1'b0;
    #1;
    check("arst_word", 64'(word_out), 64'd0);
    check("arst_len", 64'(output_len), 64'd0);
    @(posedge clk);
    #1;
    check("arst_hold_word", 64'(word_out), 64'd0);
    check("arst_hold_len", 64'(output_len), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("arst_rel_word", 64'(word_out), 64'd0);
    check("arst_rel_len", 64'(output_len), 64'd30);

    // Further directed patterns, checked by the per-cycle compare.
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      word_in = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
      if (j % 4 == 0) word_in = 40'h0F0F0F0F0F;
      if (j % 4 == 1) word_in = 40'hAAA5555AAA;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_rll_restore
